// File: rtl/ps2_key_event_ctrl.sv
// ps2_key_event_ctrl
// Takes {expand,break,code} events from the PS/2 receiver and filters typematic
// auto-repeat. Accepted events are queued in a small FIFO that the CPU reads
// over MMIO. The block also derives the flap pulse, flap held and pause toggle
// game controls.
module ps2_key_event_ctrl #(
    parameter int       DEPTH     = 8,
    parameter int       AW        = 3,
    parameter bit [7:0] KEY_FLAP  = 8'h29,
    parameter bit [7:0] KEY_PAUSE = 8'h4D
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [9:0]    kb_data,
    input  logic          kb_ready,
    input  logic          filt_en,
    input  logic          rd_en,
    input  logic          ovf_clr,
    output logic [9:0]    ev_data,
    output logic          ev_valid,
    output logic [AW:0]   ev_count,
    output logic          overflow,
    output logic          flap_pulse,
    output logic          flap_held,
    output logic          pause_state
);

    localparam logic [AW:0] FULL_CNT  = DEPTH[AW:0];
    localparam logic [8:0]  FLAP_KEY  = {1'b0, KEY_FLAP};
    localparam logic [8:0]  PAUSE_KEY = {1'b0, KEY_PAUSE};

    logic [9:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    // Last accepted make, used to recognise auto-repeat of a held key.
    logic          lm_v;
    logic [8:0]    lm_key;

    logic          make;
    logic [8:0]    key;
    logic          is_repeat;
    logic          accept;
    logic          full;
    logic          push;
    logic          pop;
    logic          drop;

    // Classify the incoming event and decide the FIFO push, pop and drop.
    always_comb begin
        make      = ~kb_data[8];
        key       = {kb_data[9], kb_data[7:0]};
        is_repeat = make & lm_v & (key == lm_key) & filt_en;
        accept    = kb_ready & ~is_repeat;
        full      = (count == FULL_CNT);
        pop       = rd_en & (count != '0);
        // When full, a same-cycle pop frees the slot that the push needs.
        push      = accept & (~full | rd_en);
        drop      = accept & full & ~rd_en;
    end

    // FIFO storage holds data only. The pointers and count decide what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= kb_data;
        end
    end

    // Control state: pointers, count, overflow sticky, last-make tracking and game outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            lm_v        <= 1'b0;
            lm_key      <= '0;
            flap_pulse  <= 1'b0;
            flap_held   <= 1'b0;
            pause_state <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

            // A set has priority over a clear in the same cycle.
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end

            if (accept && make) begin
                lm_v   <= 1'b1;
                lm_key <= key;
            end else if (kb_ready && !make && (key == lm_key)) begin
                lm_v   <= 1'b0;
            end

            // Game controls follow accepted events, whether or not the FIFO had room.
            flap_pulse <= accept & make & (key == FLAP_KEY);
            if (accept && make && (key == FLAP_KEY)) begin
                flap_held <= 1'b1;
            end else if (kb_ready && !make && (key == FLAP_KEY)) begin
                flap_held <= 1'b0;
            end
            if (accept && make && (key == PAUSE_KEY)) begin
                pause_state <= ~pause_state;
            end
        end
    end

    // The head entry is visible combinationally and reads as zero when the FIFO is empty.
    always_comb begin
        ev_valid = (count != '0);
        ev_count = count;
        ev_data  = ev_valid ? mem[rd_ptr] : 10'd0;
    end

endmodule
